// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } ifu_state_e;

  // Fetching this word ends the program when HALT_ON_ZERO is set.
  localparam int HALT_WORD = 0;

endpackage

// File: rtl/ifu_if.sv
// Control, program-write and instruction-stream signals of the fetch unit.
// The master side is the loader/decode environment; the slave side is the fetch unit.
interface ifu_if #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 16
);
  logic               start;
  logic [ADDR_W-1:0]  start_pc;
  logic               enable;
  logic               out_ready;
  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0]  instr_pc;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [INSTR_W-1:0] wr_data;
  logic               busy;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;

  modport master (
    output start, start_pc, enable, out_ready, redirect, redirect_pc,
           wr_en, wr_addr, wr_data,
    input  instr_valid, instruction, instr_pc, busy, halted, fetch_count
  );

  modport slave (
    input  start, start_pc, enable, out_ready, redirect, redirect_pc,
           wr_en, wr_addr, wr_data,
    output instr_valid, instruction, instr_pc, busy, halted, fetch_count
  );
endinterface

// File: rtl/ifu_imem.sv
// Program memory: synchronous write, combinational read, zero-filled at elaboration.
module ifu_imem #(
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  // Contents deliberately survive reset so a program can be rerun after one.
  logic [INSTR_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: walks a PC through a writable program memory and streams one
// registered instruction per cycle over a valid/ready handshake.
module instruction_fetch_unit #(
  parameter int INSTR_W      = 32,
  parameter int DEPTH        = 32,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int CNT_W        = 16,
  parameter bit HALT_ON_ZERO = 1'b1,
  parameter bit WRAP         = 1'b1
) (
  input logic  clk,
  input logic  reset,
  ifu_if.slave bus
);
  import ifu_pkg::*;

  ifu_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INSTR_W-1:0] rd_data;
  logic               is_run, redir, fetch, accept, mem_we;

  assign is_run = (state_q == RUN);
  assign redir  = is_run && bus.redirect;
  assign fetch  = is_run && bus.enable && !bus.redirect && (!valid_q || bus.out_ready);
  // A word presented during a redirect is flushed, so it never counts as delivered.
  assign accept = valid_q && bus.out_ready && !redir;
  assign mem_we = bus.wr_en && !is_run;

  ifu_imem #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (pc_q),
    .rdata (rd_data)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;

    if (!is_run && bus.start) begin
      state_d = RUN;
      pc_d    = bus.start_pc;
      valid_d = 1'b0;
      instr_d = '0;
      cnt_d   = '0;
    end else begin
      if (accept && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);

      if (redir) begin
        pc_d    = bus.redirect_pc;
        valid_d = 1'b0;
        instr_d = '0;
      end else if (fetch) begin
        if (HALT_ON_ZERO && (rd_data == INSTR_W'(HALT_WORD))) begin
          // PC stays on the terminating word's address.
          state_d = HALTED;
          valid_d = 1'b0;
          instr_d = '0;
        end else begin
          instr_d = rd_data;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + ADDR_W'(1);
          if (!WRAP && (pc_q == ADDR_W'(DEPTH - 1))) state_d = HALTED;
        end
      end else if (accept) begin
        valid_d = 1'b0;
        instr_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.instr_valid = valid_q;
  assign bus.instruction = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.busy        = (state_q == RUN);
  assign bus.halted      = (state_q == HALTED);
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a wrapping instance (a) and a
// non-wrapping instance (b), both DEPTH=32, INSTR_W=32.
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic [4:0]  pc;
    logic [31:0] word;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t sb [$];

  ifu_if #(.INSTR_W(32), .ADDR_W(5), .CNT_W(16)) aif ();
  ifu_if #(.INSTR_W(32), .ADDR_W(5), .CNT_W(16)) bif ();

  instruction_fetch_unit #(
    .INSTR_W(32), .DEPTH(32), .ADDR_W(5), .CNT_W(16), .HALT_ON_ZERO(1'b1), .WRAP(1'b1)
  ) dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (aif)
  );

  instruction_fetch_unit #(
    .INSTR_W(32), .DEPTH(32), .ADDR_W(5), .CNT_W(16), .HALT_ON_ZERO(1'b1), .WRAP(1'b0)
  ) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] pc, input logic [31:0] word);
    exp_t e;
    e.pc   = pc;
    e.word = word;
    sb.push_back(e);
  endtask

  task automatic prog_a(input logic [4:0] addr, input logic [31:0] data);
    aif.wr_en   = 1'b1;
    aif.wr_addr = addr;
    aif.wr_data = data;
    tick();
    aif.wr_en   = 1'b0;
  endtask

  task automatic wait_halted_a(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (aif.halted) break;
      tick();
    end
    check_eq("halt_wait", aif.halted, 1);
  endtask

  // Every accepted handshake on instance a is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && aif.instr_valid && aif.out_ready && !(aif.busy && aif.redirect)) begin
      check_eq("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_pc", aif.instr_pc, e.pc);
        check_eq("sb_word", aif.instruction, e.word);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    aif.start = 0; aif.start_pc = '0; aif.enable = 0; aif.out_ready = 0;
    aif.redirect = 0; aif.redirect_pc = '0; aif.wr_en = 0; aif.wr_addr = '0; aif.wr_data = '0;
    bif.start = 0; bif.start_pc = '0; bif.enable = 0; bif.out_ready = 0;
    bif.redirect = 0; bif.redirect_pc = '0; bif.wr_en = 0; bif.wr_addr = '0; bif.wr_data = '0;
    #1 rst_n = 1'b0;
    #11;
    check_eq("rst_valid", aif.instr_valid, 0);
    check_eq("rst_instr", aif.instruction, 0);
    check_eq("rst_pc", aif.instr_pc, 0);
    check_eq("rst_halted", aif.halted, 0);
    check_eq("rst_count", aif.fetch_count, 0);
    check_eq("rst_busy", aif.busy, 0);
    tick();
    rst_n = 1'b1;

    // Basic run to a zero word
    prog_a(5'd0, 32'h1111_1111);
    prog_a(5'd1, 32'h2222_2222);
    prog_a(5'd2, 32'h3333_3333);
    prog_a(5'd3, 32'h0000_0000);
    prog_a(5'd5, 32'h5555_5555);
    push(5'd0, 32'h1111_1111);
    push(5'd1, 32'h2222_2222);
    push(5'd2, 32'h3333_3333);
    aif.enable = 1; aif.out_ready = 1; aif.start = 1; aif.start_pc = 5'd0;
    tick();
    aif.start = 0;
    check_eq("lat_edge1_valid", aif.instr_valid, 0);
    check_eq("lat_edge1_busy", aif.busy, 1);
    tick();
    check_eq("lat_edge2_valid", aif.instr_valid, 1);
    wait_halted_a(20);
    check_eq("run1_valid", aif.instr_valid, 0);
    check_eq("run1_instr", aif.instruction, 0);
    check_eq("run1_count", aif.fetch_count, 3);

    // Backpressure, then redirect while 0x22222222 is presented
    push(5'd0, 32'h1111_1111);
    push(5'd5, 32'h5555_5555);
    aif.out_ready = 0; aif.start = 1; aif.start_pc = 5'd0;
    tick();
    aif.start = 0;
    check_eq("bp_start_count", aif.fetch_count, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp_hold_instr", aif.instruction, 32'h1111_1111);
      check_eq("bp_hold_pc", aif.instr_pc, 0);
      check_eq("bp_hold_count", aif.fetch_count, 0);
    end
    aif.out_ready = 1;
    tick();
    check_eq("bp_release_instr", aif.instruction, 32'h2222_2222);
    check_eq("bp_release_pc", aif.instr_pc, 1);
    check_eq("bp_release_count", aif.fetch_count, 1);
    aif.redirect = 1; aif.redirect_pc = 5'd5;
    tick();
    aif.redirect = 0;
    check_eq("redir_valid", aif.instr_valid, 0);
    check_eq("redir_instr", aif.instruction, 0);
    check_eq("redir_count", aif.fetch_count, 1);
    tick();
    check_eq("redir_target_valid", aif.instr_valid, 1);
    check_eq("redir_target_instr", aif.instruction, 32'h5555_5555);
    check_eq("redir_target_pc", aif.instr_pc, 5);
    tick();
    check_eq("redir_end_halted", aif.halted, 1);
    check_eq("redir_end_count", aif.fetch_count, 2);

    // enable=0 drain, and a write attempt while running
    push(5'd0, 32'h1111_1111);
    push(5'd1, 32'h2222_2222);
    push(5'd2, 32'h3333_3333);
    aif.enable = 1; aif.out_ready = 1; aif.start = 1; aif.start_pc = 5'd0;
    tick();
    aif.start = 0;
    aif.wr_en = 1; aif.wr_addr = 5'd1; aif.wr_data = 32'hDEAD_BEEF;
    tick();
    aif.wr_en = 0;
    aif.enable = 0;
    check_eq("en_first_instr", aif.instruction, 32'h1111_1111);
    tick();
    check_eq("en_drain_valid", aif.instr_valid, 0);
    check_eq("en_drain_instr", aif.instruction, 0);
    check_eq("en_drain_count", aif.fetch_count, 1);
    tick();
    check_eq("en_idle_valid", aif.instr_valid, 0);
    check_eq("en_idle_busy", aif.busy, 1);
    aif.enable = 1;
    tick();
    check_eq("en_resume_instr", aif.instruction, 32'h2222_2222);
    check_eq("en_resume_pc", aif.instr_pc, 1);
    wait_halted_a(20);
    check_eq("en_end_count", aif.fetch_count, 3);

    // Asynchronous reset between edges
    push(5'd0, 32'h1111_1111);
    aif.start = 1; aif.start_pc = 5'd0;
    tick();
    aif.start = 0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", aif.instr_valid, 0);
    check_eq("arst_instr", aif.instruction, 0);
    check_eq("arst_pc", aif.instr_pc, 0);
    check_eq("arst_halted", aif.halted, 0);
    check_eq("arst_count", aif.fetch_count, 0);
    check_eq("arst_busy", aif.busy, 0);
    tick();
    rst_n = 1'b1;
    push(5'd0, 32'h1111_1111);
    push(5'd1, 32'h2222_2222);
    push(5'd2, 32'h3333_3333);
    aif.start = 1; aif.start_pc = 5'd0;
    tick();
    aif.start = 0;
    wait_halted_a(20);
    check_eq("arst_rerun_count", aif.fetch_count, 3);

    // Fill every word nonzero in both instances, then run across the top
    aif.enable = 0;
    for (int i = 0; i < 32; i++) begin
      aif.wr_en = 1; aif.wr_addr = 5'(i); aif.wr_data = 32'hA500_0000 | 32'(i);
      bif.wr_en = 1; bif.wr_addr = 5'(i); bif.wr_data = 32'hA500_0000 | 32'(i);
      tick();
    end
    aif.wr_en = 0;
    bif.wr_en = 0;
    push(5'd30, 32'hA500_001E);
    push(5'd31, 32'hA500_001F);
    push(5'd0,  32'hA500_0000);
    push(5'd1,  32'hA500_0001);
    aif.enable = 1; aif.out_ready = 1; aif.start = 1; aif.start_pc = 5'd30;
    tick();
    aif.start = 0;
    for (int i = 0; i < 4; i++) tick();
    aif.enable = 0;
    tick();
    check_eq("wrap_drain_valid", aif.instr_valid, 0);
    check_eq("wrap_still_busy", aif.busy, 1);
    check_eq("wrap_count", aif.fetch_count, 4);

    bif.enable = 1; bif.out_ready = 1; bif.start = 1; bif.start_pc = 5'd30;
    tick();
    bif.start = 0;
    tick();
    check_eq("nowrap_pc30", bif.instr_pc, 30);
    check_eq("nowrap_valid30", bif.instr_valid, 1);
    tick();
    check_eq("nowrap_pc31", bif.instr_pc, 31);
    check_eq("nowrap_valid31", bif.instr_valid, 1);
    check_eq("nowrap_instr31", bif.instruction, 32'hA500_001F);
    check_eq("nowrap_halted", bif.halted, 1);
    tick();
    check_eq("nowrap_drain_valid", bif.instr_valid, 0);
    check_eq("nowrap_drain_instr", bif.instruction, 0);
    check_eq("nowrap_drain_halted", bif.halted, 1);
    check_eq("nowrap_count", bif.fetch_count, 2);

    check_eq("sb_leftover", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
